mem_dma: RTL and testbench

Byte-copy engine acting as the bus master upstream of the 8-bit RAM on the mem8 bus. Given source address, destination address and length, it sequences read and write cycles, driving address, `cs`, `oe`, `we` and the shared tri-state data bus. A CPU-side start/busy/done handshake hands bulk transfers off from the processor.

---
 rtl/mem8_pkg.sv | 22 ++
 rtl/mem_dma_if.sv | 15 +
 rtl/mem_dma_bus_if.sv | 86 ++++++++
 rtl/mem_dma.sv | 138 +++++++++++++
 tb/tb_mem_dma.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem8_pkg.sv
// Shared definitions for the mem8 bus: DMA state encoding, default bus widths
// and the size of the 8-bit RAM that sits on the bus.
package mem8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

  localparam int MEM8_ADDR_W    = 16;
  localparam int MEM8_DATA_W    = 8;
  localparam int MEM8_RAM_BYTES = 1024;
  localparam int MEM8_RAM_AW    = 10;

  // The RAM decodes only the low address bits, so higher addresses alias.
  function automatic logic [MEM8_RAM_AW-1:0] ram_index(input logic [MEM8_ADDR_W-1:0] addr);
    return addr[MEM8_RAM_AW-1:0];
  endfunction

endpackage

// File: rtl/mem_dma_if.sv
// mem8 bus address and strobe bundle; the shared data lines stay a plain
// inout wire so that several tri-state drivers can resolve on it.
interface mem_dma_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_cs;
  logic              bus_oe;
  logic              bus_we;

  modport master (output bus_addr, output bus_cs, output bus_oe, output bus_we);
  modport slave  (input  bus_addr, input  bus_cs, input  bus_oe, input  bus_we);

endinterface

// File: rtl/mem_dma_bus_if.sv
// Bus pin stage of mem_dma: registered address/strobes, the tri-state data
// driver and the read-data capture register.
module mem_dma_bus_if
  import mem8_pkg::*;
#(
  parameter int ADDR_W = MEM8_ADDR_W,
  parameter int DATA_W = MEM8_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  dma_state_t         st_r,
  input  dma_state_t         st_nxt,
  input  logic [ADDR_W-1:0]  src_nxt,
  input  logic [ADDR_W-1:0]  dst_nxt,
  input  logic               fill_sel,
  input  logic [DATA_W-1:0]  fill_val,
  mem_dma_if.master          bus,
  inout  wire  [DATA_W-1:0]  bus_data
);

  logic [ADDR_W-1:0] addr_s, addr_r;
  logic              cs_s, oe_s, we_s;
  logic              cs_r, oe_r, we_r, drv_r;
  logic [DATA_W-1:0] byte_q_r;
  logic [DATA_W-1:0] wdata_s;

  // Pin values for the state about to be entered; registering them keeps
  // the strobes glitch-free and aligned with the registered state.
  always_comb begin
    addr_s = '0;
    cs_s   = 1'b0;
    oe_s   = 1'b0;
    we_s   = 1'b0;
    case (st_nxt)
      ST_READ: begin
        addr_s = src_nxt;
        cs_s   = 1'b1;
        oe_s   = 1'b1;
      end
      ST_WRITE: begin
        addr_s = dst_nxt;
        cs_s   = 1'b1;
        we_s   = 1'b1;
      end
      default: begin
        addr_s = '0;
      end
    endcase
  end

  // Pin registers; async reset releases the bus without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      cs_r   <= 1'b0;
      oe_r   <= 1'b0;
      we_r   <= 1'b0;
      drv_r  <= 1'b0;
    end else begin
      addr_r <= addr_s;
      cs_r   <= cs_s;
      oe_r   <= oe_s;
      we_r   <= we_s;
      drv_r  <= we_s;
    end
  end

  // Read-data capture at the end of each READ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q_r <= '0;
    end else if (st_r == ST_READ) begin
      byte_q_r <= bus_data;
    end else begin
      byte_q_r <= byte_q_r;
    end
  end

  assign wdata_s      = fill_sel ? fill_val : byte_q_r;
  assign bus_data     = drv_r ? wdata_s : {DATA_W{1'bz}};
  assign bus.bus_addr = addr_r;
  assign bus.bus_cs   = cs_r;
  assign bus.bus_oe   = oe_r;
  assign bus.bus_we   = we_r;

endmodule

// File: rtl/mem_dma.sv
// Byte-copy DMA master for the mem8 bus: FSM, pointers and byte counter.
// Optional MEM_DMA_FILL_EN adds a fill mode (write-only, 1 cycle per byte).
module mem_dma
  import mem8_pkg::*;
#(
  parameter int ADDR_W = MEM8_ADDR_W,
  parameter int DATA_W = MEM8_DATA_W,
  parameter int LEN_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_addr,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [LEN_W-1:0]   len,
`ifdef MEM_DMA_FILL_EN
  input  logic               fill,
  input  logic [DATA_W-1:0]  fill_value,
`endif
  output logic               busy,
  output logic               done,
  mem_dma_if.master          bus,
  inout  wire  [DATA_W-1:0]  bus_data
);

  dma_state_t        st_r, st_nxt_s;
  logic [ADDR_W-1:0] src_r, dst_r, src_nxt_s, dst_nxt_s;
  logic [LEN_W-1:0]  rem_r, rem_nxt_s;
  logic              fill_r, fill_nxt_s, fill_in_s;
  logic [DATA_W-1:0] fval_r, fval_nxt_s, fval_in_s;
  logic              busy_s, done_s;
  logic              accept_s;

`ifdef MEM_DMA_FILL_EN
  assign fill_in_s = fill;
  assign fval_in_s = fill_value;
`else
  assign fill_in_s = 1'b0;
  assign fval_in_s = '0;
`endif

  assign accept_s = (st_r == ST_IDLE) && start;

  // Next-state logic.
  always_comb begin
    st_nxt_s = st_r;
    case (st_r)
      ST_IDLE: begin
        if (!start) begin
          st_nxt_s = ST_IDLE;
        end else if (len == '0) begin
          st_nxt_s = ST_DONE;
        end else begin
          st_nxt_s = fill_in_s ? ST_WRITE : ST_READ;
        end
      end
      ST_READ:  st_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (rem_r == LEN_W'(1)) begin
          st_nxt_s = ST_DONE;
        end else begin
          st_nxt_s = fill_r ? ST_WRITE : ST_READ;
        end
      end
      ST_DONE:  st_nxt_s = ST_IDLE;
      default:  st_nxt_s = ST_IDLE;
    endcase
  end

  // Pointer/counter updates: latch on accept, step after every WRITE.
  always_comb begin
    src_nxt_s  = src_r;
    dst_nxt_s  = dst_r;
    rem_nxt_s  = rem_r;
    fill_nxt_s = fill_r;
    fval_nxt_s = fval_r;
    if (accept_s) begin
      src_nxt_s  = src_addr;
      dst_nxt_s  = dst_addr;
      rem_nxt_s  = len;
      fill_nxt_s = fill_in_s;
      fval_nxt_s = fval_in_s;
    end else if (st_r == ST_WRITE) begin
      src_nxt_s = src_r + ADDR_W'(1);
      dst_nxt_s = dst_r + ADDR_W'(1);
      rem_nxt_s = rem_r - LEN_W'(1);
    end else begin
      src_nxt_s = src_r;
      dst_nxt_s = dst_r;
    end
  end

  // Output decode from the state being entered, registered below.
  always_comb begin
    busy_s = (st_nxt_s != ST_IDLE);
    done_s = (st_nxt_s == ST_DONE);
  end

  // State, datapath and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r   <= ST_IDLE;
      src_r  <= '0;
      dst_r  <= '0;
      rem_r  <= '0;
      fill_r <= 1'b0;
      fval_r <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      st_r   <= st_nxt_s;
      src_r  <= src_nxt_s;
      dst_r  <= dst_nxt_s;
      rem_r  <= rem_nxt_s;
      fill_r <= fill_nxt_s;
      fval_r <= fval_nxt_s;
      busy   <= busy_s;
      done   <= done_s;
    end
  end

  mem_dma_bus_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_r     (st_r),
    .st_nxt   (st_nxt_s),
    .src_nxt  (src_nxt_s),
    .dst_nxt  (dst_nxt_s),
    .fill_sel (fill_r),
    .fill_val (fval_r),
    .bus      (bus),
    .bus_data (bus_data)
  );

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma with a 1 KiB aliasing RAM model and a
// scoreboard of expected bus cycles. Covers MEM_DMA_FILL_EN when defined.
module tb_mem_dma;
  import mem8_pkg::*;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src_addr, dst_addr, len;
  logic        busy, done;
  logic        preload;
  wire  [7:0]  bus_data;
`ifdef MEM_DMA_FILL_EN
  logic        fill;
  logic [7:0]  fill_value;
`endif

  logic [7:0]  ram [0:1023];
  cyc_t        sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  mem_dma_if #(.ADDR_W(16)) bus ();

  mem_dma #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef MEM_DMA_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .bus        (bus),
    .bus_data   (bus_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [9:0] a);
    if (a < 10'd16) return 8'h10 + {4'h0, a[3:0]};
    else            return a[7:0] ^ 8'h5A ^ {6'h00, a[9:8]};
  endfunction

  // RAM model: combinational read onto the bus, write on posedge.
  wire ram_rd_en = bus.bus_cs & bus.bus_oe & ~bus.bus_we;
  assign bus_data = ram_rd_en ? ram[ram_index(bus.bus_addr)] : 8'hzz;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(10'(i));
    end else if (bus.bus_cs && bus.bus_we) begin
      ram[ram_index(bus.bus_addr)] <= bus_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      logic [15:0] sa;
      logic [15:0] da;
      sa = s + 16'(k);
      da = d + 16'(k);
      sb_q.push_back('{we: 1'b0, addr: sa, data: 8'h00});
      sb_q.push_back('{we: 1'b1, addr: da, data: init_byte(ram_index(sa))});
    end
  endtask

  // Start a transfer, then watch the bus for up to budget cycles.
  task automatic run_xfer(input int budget, input int exp_done, input int restart_at, input int rst_at);
    int   done_cnt;
    int   done_at;
    int   conflicts;
    cyc_t e;
    done_cnt  = 0;
    done_at   = 0;
    conflicts = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = 16'h0ABC;
    dst_addr = 16'h0DEF;
    len      = 16'h0003;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (bus.bus_oe && bus.bus_we) conflicts++;
      if (n == 1) check_eq("busy_rise", {31'd0, busy}, 32'd1);
      if (exp_done > 0 && n == exp_done + 1) check_eq("busy_fall", {31'd0, busy}, 32'd0);
      if (bus.bus_cs) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", {16'd0, bus.bus_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_we", {31'd0, bus.bus_we}, {31'd0, e.we});
          check_eq("sb_addr", {16'd0, bus.bus_addr}, {16'd0, e.addr});
          if (e.we) check_eq("sb_data", {24'd0, bus_data}, {24'd0, e.data});
        end
      end
      start = (n == restart_at) ? 1'b1 : 1'b0;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_strobes", {29'd0, bus.bus_cs, bus.bus_oe, bus.bus_we}, 32'd0);
        check_eq("rst_bus_z", {31'd0, dut.u_bus.drv_r}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        break;
      end
    end
    start = 1'b0;
    if (exp_done == 0) begin
      check_eq("done_none", 32'(done_cnt), 32'd0);
    end else begin
      check_eq("done_count", 32'(done_cnt), 32'd1);
      check_eq("done_cycle", 32'(done_at), 32'(exp_done));
    end
    check_eq("no_contention", 32'(conflicts), 32'd0);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = 16'h0000;
    dst_addr = 16'h0000;
    len      = 16'h0000;
    preload  = 1'b1;
`ifdef MEM_DMA_FILL_EN
    fill       = 1'b0;
    fill_value = 8'h00;
`endif
    @(posedge clk);
    #1;
    preload = 1'b0;
    @(negedge clk);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_strobes", {29'd0, bus.bus_cs, bus.bus_oe, bus.bus_we}, 32'd0);
    check_eq("rst_addr", {16'd0, bus.bus_addr}, 32'd0);
    check_eq("rst_drv", {31'd0, dut.u_bus.drv_r}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 16-byte copy 0x000 -> 0x100
    src_addr = 16'h0000; dst_addr = 16'h0100; len = 16'd16;
    push_copy(16'h0000, 16'h0100, 16);
    run_xfer(40, 33, 0, 0);
    for (int i = 0; i < 16; i++)
      check_eq("copy16_ram", {24'd0, ram[16'h0100 + i]}, 32'h10 + 32'(i));

    // zero length: done only, no bus activity
    src_addr = 16'h0000; dst_addr = 16'h0000; len = 16'd0;
    run_xfer(6, 1, 0, 0);
    check_eq("len0_ram", {24'd0, ram[0]}, 32'h10);

    // source wraps 0xFFFF -> 0x0000, RAM aliases on 10 bits
    src_addr = 16'hFFFE; dst_addr = 16'h0200; len = 16'd4;
    push_copy(16'hFFFE, 16'h0200, 4);
    run_xfer(12, 9, 0, 0);
    check_eq("wrap_ram0", {24'd0, ram[10'h200]}, {24'd0, init_byte(10'h3FE)});
    check_eq("wrap_ram2", {24'd0, ram[10'h202]}, 32'h10);
    check_eq("wrap_ram3", {24'd0, ram[10'h203]}, 32'h11);

    // start re-pulsed in cycle 5 is ignored
    src_addr = 16'h0020; dst_addr = 16'h0280; len = 16'd8;
    push_copy(16'h0020, 16'h0280, 8);
    run_xfer(22, 17, 5, 0);
    check_eq("restart_ram7", {24'd0, ram[10'h287]}, {24'd0, init_byte(10'h027)});

    // reset during WRITE of byte 3 (cycle 8)
    src_addr = 16'h0040; dst_addr = 16'h0300; len = 16'd8;
    push_copy(16'h0040, 16'h0300, 4);
    run_xfer(20, 0, 0, 8);
    repeat (3) @(negedge clk);
    check_eq("rst_no_done", {30'd0, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_byte2", {24'd0, ram[10'h302]}, {24'd0, init_byte(10'h042)});
    check_eq("rst_byte3", {24'd0, ram[10'h303]}, {24'd0, init_byte(10'h303)});

`ifdef MEM_DMA_FILL_EN
    // fill mode: write-only, 1 cycle per byte
    fill = 1'b1; fill_value = 8'hA5;
    src_addr = 16'h0000; dst_addr = 16'h0040; len = 16'd5;
    for (int k = 0; k < 5; k++)
      sb_q.push_back('{we: 1'b1, addr: 16'h0040 + 16'(k), data: 8'hA5});
    run_xfer(10, 6, 0, 0);
    fill = 1'b0;
    for (int k = 0; k < 5; k++)
      check_eq("fill_ram", {24'd0, ram[16'h0040 + k]}, 32'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
